// File: rtl/mem_path.sv
// Memory path for the 8-bit processor: PC, MAR, MBR, IR and a unified RAM.
// A bench-side loader port can preload the RAM.
module mem_path #(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 8,
    parameter logic [3:0]  DATA_PAGE = 4'hF
) (
    input  logic              MEM_clk,
    input  logic              MEM_rst,
    input  logic              PC_inc,
    input  logic              MAR_rw,
    input  logic              MAR_select,
    input  logic              MBR_rw,
    input  logic              MBR_select,
    input  logic              RAM_rw,
    input  logic              IR_rw,
    input  logic [DATA_W-1:0] Reg_data,
    input  logic              Load_en,
    input  logic [ADDR_W-1:0] Load_addr,
    input  logic [DATA_W-1:0] Load_data,
    output logic [DATA_W-1:0] IR_out,
    output logic [DATA_W-1:0] MBR_out,
    output logic [ADDR_W-1:0] PC_out,
    output logic [ADDR_W-1:0] MAR_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] ram [DEPTH];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] data_addr;

    // LD/ST operands live in a fixed page addressed by the low IR nibble
    assign data_addr = ADDR_W'({DATA_PAGE, ir_q[3:0]});

    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        ir_d  = ir_q;
        if (PC_inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
        if (MAR_rw) begin
            mar_d = MAR_select ? data_addr : pc_q;
        end
        if (IR_rw) begin
            ir_d = mbr_q;
        end
    end

    always_ff @(posedge MEM_clk) begin
        if (MEM_rst) begin
            pc_q  <= '0;
            mar_q <= '0;
            mbr_q <= '0;
            ir_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            ir_q  <= ir_d;
            if (MBR_rw) begin
                // Read-before-write: a concurrent RAM_rw leaves the old word here
                mbr_q <= MBR_select ? Reg_data : ram[mar_q];
            end
        end
    end

    // Loader wins over the CU write and stays active during reset
    always_ff @(posedge MEM_clk) begin
        if (Load_en) begin
            ram[Load_addr] <= Load_data;
        end else if (RAM_rw && !MEM_rst) begin
            ram[mar_q] <= mbr_q;
        end
    end

    assign IR_out  = ir_q;
    assign MBR_out = mbr_q;
    assign PC_out  = pc_q;
    assign MAR_out = mar_q;

endmodule

// File: tb/tb_mem_path.sv
// Directed and random checks of mem_path against a cycle-level reference model.
module tb_mem_path;

    logic       MEM_clk = 1'b0;
    logic       MEM_rst;
    logic       PC_inc, MAR_rw, MAR_select, MBR_rw, MBR_select, RAM_rw, IR_rw;
    logic [7:0] Reg_data;
    logic       Load_en;
    logic [7:0] Load_addr, Load_data;
    logic [7:0] IR_out, MBR_out, PC_out, MAR_out;

    mem_path dut (
        .MEM_clk    (MEM_clk),
        .MEM_rst    (MEM_rst),
        .PC_inc     (PC_inc),
        .MAR_rw     (MAR_rw),
        .MAR_select (MAR_select),
        .MBR_rw     (MBR_rw),
        .MBR_select (MBR_select),
        .RAM_rw     (RAM_rw),
        .IR_rw      (IR_rw),
        .Reg_data   (Reg_data),
        .Load_en    (Load_en),
        .Load_addr  (Load_addr),
        .Load_data  (Load_data),
        .IR_out     (IR_out),
        .MBR_out    (MBR_out),
        .PC_out     (PC_out),
        .MAR_out    (MAR_out)
    );

    always #5 MEM_clk = ~MEM_clk;

    // Reference model state
    int m_ram [256];
    int m_pc, m_mar, m_mbr, m_ir;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        MEM_rst = 0; PC_inc = 0; MAR_rw = 0; MAR_select = 0;
        MBR_rw = 0; MBR_select = 0; RAM_rw = 0; IR_rw = 0;
        Load_en = 0; Load_addr = 8'h00; Load_data = 8'h00; Reg_data = 8'h00;
    endtask

    // One clock edge: advance the model from the pre-edge state, then compare.
    task automatic tick();
        int old_pc, old_mar, old_mbr, old_ir, rd;
        @(posedge MEM_clk);
        old_pc = m_pc; old_mar = m_mar; old_mbr = m_mbr; old_ir = m_ir;
        rd = m_ram[old_mar];
        if (Load_en)
            m_ram[Load_addr] = Load_data;
        else if (RAM_rw && !MEM_rst)
            m_ram[old_mar] = old_mbr;
        if (MEM_rst) begin
            m_pc = 0; m_mar = 0; m_mbr = 0; m_ir = 0;
        end else begin
            if (PC_inc) m_pc = (old_pc + 1) % 256;
            if (MAR_rw) m_mar = MAR_select ? (16'hF0 + (old_ir % 16)) : old_pc;
            if (MBR_rw) m_mbr = MBR_select ? int'(Reg_data) : rd;
            if (IR_rw)  m_ir = old_mbr;
        end
        #1;
        chk("pc",  PC_out,  8'(m_pc));
        chk("mar", MAR_out, 8'(m_mar));
        chk("mbr", MBR_out, 8'(m_mbr));
        chk("ir",  IR_out,  8'(m_ir));
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        idle(); Load_en = 1; Load_addr = a; Load_data = d; tick(); idle();
    endtask

    task automatic fetch();
        idle(); MAR_rw = 1; tick();
        idle(); MBR_rw = 1; PC_inc = 1; tick();
        idle(); IR_rw = 1; tick();
        idle();
    endtask

    task automatic pc_to(input int target);
        int guard = 0;
        idle(); PC_inc = 1;
        while (m_pc != target && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) begin
            n_assert++; n_fail++;
            $error("FAIL pc_to observed=%02h expected=%02h", PC_out, 8'(target));
        end
        idle();
    endtask

    task automatic set_mbr(input logic [7:0] v);
        idle(); MBR_rw = 1; MBR_select = 1; Reg_data = v; tick(); idle();
    endtask

    initial begin
        m_pc = 0; m_mar = 0; m_mbr = 0; m_ir = 0;
        idle();

        // Reset, and preload every RAM word through the loader while reset is held
        MEM_rst = 1; tick();
        chk("rst_pc", PC_out, 8'h00);
        chk("rst_ir", IR_out, 8'h00);
        for (int a = 0; a < 256; a++) begin
            MEM_rst = 1; Load_en = 1; Load_addr = 8'(a);
            Load_data = (a == 0) ? 8'h2D : 8'($urandom_range(0, 255));
            tick();
        end
        idle();

        // Fetch from address 00
        fetch();
        chk("fetch_ir", IR_out, 8'h2D);
        chk("fetch_pc", PC_out, 8'h01);

        // LD: IR=05, RAM[F5]=A7
        load(8'h01, 8'h05);
        load(8'hF5, 8'hA7);
        fetch();
        chk("ld_ir", IR_out, 8'h05);
        MAR_rw = 1; MAR_select = 1; tick(); idle();
        chk("ld_mar", MAR_out, 8'hF5);
        MBR_rw = 1; tick(); idle();
        chk("ld_mbr", MBR_out, 8'hA7);

        // ST: IR=13, Reg_data=3C
        load(8'h02, 8'h13);
        fetch();
        chk("st_ir", IR_out, 8'h13);
        MAR_rw = 1; MAR_select = 1; tick(); idle();
        chk("st_mar", MAR_out, 8'hF3);
        set_mbr(8'h3C);
        RAM_rw = 1; tick(); idle();
        set_mbr(8'h00);
        MBR_rw = 1; tick(); idle();
        chk("st_readback", MBR_out, 8'h3C);

        // PC wrap with a same-cycle MAR load
        pc_to(255);
        PC_inc = 1; MAR_rw = 1; tick(); idle();
        chk("wrap_pc", PC_out, 8'h00);
        chk("wrap_mar", MAR_out, 8'hFF);

        // Loader priority over RAM_rw
        pc_to(16);
        MAR_rw = 1; tick(); idle();
        set_mbr(8'h55);
        RAM_rw = 1; Load_en = 1; Load_addr = 8'h10; Load_data = 8'h99; tick(); idle();
        MBR_rw = 1; tick(); idle();
        chk("prio_ram10", MBR_out, 8'h99);

        // Read/write collision returns the old word
        load(8'h20, 8'h11);
        pc_to(32);
        MAR_rw = 1; tick(); idle();
        set_mbr(8'h77);
        MBR_rw = 1; RAM_rw = 1; tick(); idle();
        chk("coll_mbr", MBR_out, 8'h11);
        MBR_rw = 1; tick(); idle();
        chk("coll_ram20", MBR_out, 8'h77);

        // Reset mid-operation with PC=42, IR=30
        load(8'h41, 8'h30);
        pc_to(65);
        fetch();
        chk("mid_pc", PC_out, 8'h42);
        chk("mid_ir", IR_out, 8'h30);
        MEM_rst = 1; PC_inc = 1; IR_rw = 1; RAM_rw = 1; MAR_rw = 1; MBR_rw = 1; tick(); idle();
        chk("mid_rst_pc", PC_out, 8'h00);
        chk("mid_rst_mar", MAR_out, 8'h00);
        chk("mid_rst_mbr", MBR_out, 8'h00);
        chk("mid_rst_ir", IR_out, 8'h00);
        MBR_rw = 1; tick(); idle();
        chk("mid_ram00", MBR_out, 8'h2D);
        load(8'h00, 8'h00);
        MAR_rw = 1; MAR_select = 0; pc_to(65); MAR_rw = 1; tick(); idle();
        MBR_rw = 1; tick(); idle();
        chk("mid_ram41", MBR_out, 8'h30);

        // Random strobe combinations against the model
        for (int i = 0; i < 400; i++) begin
            MEM_rst    = ($urandom_range(0, 31) == 0);
            PC_inc     = 1'($urandom);
            MAR_rw     = 1'($urandom);
            MAR_select = 1'($urandom);
            MBR_rw     = 1'($urandom);
            MBR_select = 1'($urandom);
            RAM_rw     = 1'($urandom);
            IR_rw      = 1'($urandom);
            Reg_data   = 8'($urandom);
            Load_en    = ($urandom_range(0, 7) == 0);
            Load_addr  = 8'($urandom);
            Load_data  = 8'($urandom);
            tick();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_path.md
Name: mem_path

Overview:
Instruction/data memory path for the 8-bit processor. It holds PC, MAR, MBR, IR and a 256x8 unified RAM, and executes the CU strobes (PC_inc, MAR_rw, MAR_select, MBR_rw, MBR_select, RAM_rw, IR_rw). It sits directly upstream of the CU: IR_out drives CU_in. It also sits beside the register file: MBR_out supplies load and immediate data, and Reg_data supplies store data. A bench-side loader port preloads programs.

Parameters:
DATA_W, 8, word width of RAM, MBR, IR and all data ports
ADDR_W, 8, width of PC, MAR and RAM address; RAM depth = 2**ADDR_W
DATA_PAGE, 4'hF, upper address nibble used for LD/ST operand addresses

Ports:
MEM_clk  input  1  single clock; all state updates on rising edge
MEM_rst  input  1  synchronous, active-high reset
PC_inc  input  1  CU: increment PC
MAR_rw  input  1  CU: load MAR
MAR_select  input  1  CU: MAR source, 0 = PC, 1 = {DATA_PAGE, IR[3:0]}
MBR_rw  input  1  CU: load MBR
MBR_select  input  1  CU: MBR source, 0 = RAM[MAR], 1 = Reg_data
RAM_rw  input  1  CU: write MBR into RAM[MAR]
IR_rw  input  1  CU: load IR from MBR
Reg_data  input  8  register-file store data (R0 during ST)
Load_en  input  1  loader write strobe
Load_addr  input  8  loader address
Load_data  input  8  loader data
IR_out  output  8  IR contents, to CU_in
MBR_out  output  8  MBR contents, to register file / immediate path
PC_out  output  8  PC contents (debug)
MAR_out  output  8  MAR contents (debug)

Behaviour:
- Reset: when MEM_rst=1 at a rising edge, PC, MAR, MBR and IR are set to 8'h00. Reset overrides every strobe that cycle. RAM contents are untouched, and Load_en is still honoured during reset.
- All registers update only on a rising edge. Outputs are the register values directly, with no combinational path from strobes.
- PC: when PC_inc=1, PC <= PC+1 modulo 256, so 8'hFF wraps to 8'h00. Otherwise PC holds.
- MAR: when MAR_rw=1, MAR <= PC if MAR_select=0, else MAR <= {DATA_PAGE, IR[3:0]}. A MAR load uses the PC value from before any PC_inc in the same cycle.
- MBR: when MBR_rw=1, MBR <= RAM[MAR] if MBR_select=0, else MBR <= Reg_data. One-cycle latency: data is visible on MBR_out the cycle after the strobe.
- RAM read is synchronous into MBR only. RAM is never presented combinationally.
- RAM write: when RAM_rw=1 and Load_en=0, RAM[MAR] <= MBR, using pre-edge MAR and MBR.
- Simultaneous MBR_rw (select 0) and RAM_rw: the read returns the old RAM word.
- IR: when IR_rw=1, IR <= MBR, using the pre-edge MBR.
- Loader: when Load_en=1, RAM[Load_addr] <= Load_data. Load_en has priority, so a concurrent RAM_rw is dropped. Loader writes do not affect PC, MAR, MBR or IR.
- Expected CU fetch timing: cycle s0 gives MAR=PC; s1 gives MBR=RAM[PC] and PC+1; s2 gives IR=MBR. An instruction therefore appears on IR_out 3 edges after fetch start.
- LD timing: s4 gives MAR={F,IR[3:0]}; s13 gives MBR=RAM; MBR_out is valid during s14.
- ST timing: s4 gives MAR; s15 gives MBR=Reg_data; s16 gives RAM write.
- Strobes are independent. Any combination is legal and is resolved by the rules above with no additional interlock.

Test Plan:
- Fetch: load RAM[00]=8'h2D, release reset, apply MAR_rw, then MBR_rw+PC_inc, then IR_rw on consecutive cycles -> IR_out=8'h2D, PC_out=8'h01 after the 3rd edge.
- LD: IR=8'h05, RAM[F5]=8'hA7, apply MAR_rw+MAR_select then MBR_rw -> MAR_out=8'hF5, then MBR_out=8'hA7.
- ST: IR=8'h13, Reg_data=8'h3C, apply MAR_rw+MAR_select, then MBR_rw+MBR_select, then RAM_rw; read back via a select-0 MBR_rw -> MBR_out=8'h3C and RAM[F3]=8'h3C.
- PC wrap: PC=8'hFF, PC_inc=1 -> PC_out=8'h00. MAR_rw in the same cycle -> MAR_out=8'hFF.
- Priority: RAM_rw=1 with MAR=8'h10 and MBR=8'h55, plus Load_en=1 with Load_addr=8'h10 and Load_data=8'h99 in the same cycle -> RAM[10]=8'h99. Read/write collision: RAM[20]=8'h11, MAR=8'h20, MBR=8'h77, with MBR_rw and RAM_rw together -> MBR_out=8'h11 and RAM[20]=8'h77.
- Reset mid-operation: PC=8'h42, IR=8'h30, assert MEM_rst together with PC_inc and IR_rw -> PC, MAR, MBR and IR all 8'h00 next cycle, and RAM contents are unchanged.
